// File: rtl/spi_pkg.sv
// Shared SPI definitions: default word width, transfer state encoding and
// the meaning of the mode bits. Used by both the master and slave sides.
package spi_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spiState_t;

  localparam logic CPOL_IDLE_LOW    = 1'b0;
  localparam logic CPHA_LEAD_SAMPLE = 1'b0;
  localparam logic ORDER_LSB_FIRST  = 1'b1;

endpackage

// File: rtl/spi_slave_shifter_if.sv
// Pin and host-side bundle of the SPI slave shifter. The slave modport is
// the shifter's view; the master modport is the view of whatever drives it
// (external SPI master pins plus the local transmit/receive client).
interface spi_slave_shifter_if import spi_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpol;
  logic              cpha;
  logic              lsb;
  logic              sclk;
  logic              ss_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  cpol, cpha, lsb, sclk, ss_n, mosi, tx_data, tx_load,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

  modport master (
    output cpol, cpha, lsb, sclk, ss_n, mosi, tx_data, tx_load,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, busy
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a third flop so that
// rising and falling transitions of the synchronised level can be flagged.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din_i,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [2:0] pipe_q;

  // Shift the raw pin through the synchroniser and edge-history flops.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      pipe_q <= {3{RESET_VAL}};
    end else begin
      pipe_q <= {pipe_q[1:0], din_i};
    end
  end

  assign level = pipe_q[1];
  assign rise  = pipe_q[1] & ~pipe_q[2];
  assign fall  = ~pipe_q[1] & pipe_q[2];

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI slave shift engine. All SPI pins are oversampled in the clk_in domain;
// received bits are assembled into rx_data and transmit words come from a
// one-entry buffer that is reloaded at select and at every word boundary.
module spi_slave_shifter import spi_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
) (
  input logic                clk_in,
  input logic                rst,
  spi_slave_shifter_if.slave bus
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic sclkLevel, sclkRise, sclkFall;
  logic ssLevel, ssRise, ssFall;
  logic [1:0] mosiSync_q;
  logic mosiS;

  spiState_t         state_q, state_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [DATA_W-1:0] txSr_q, txSr_d;
  logic [DATA_W-1:0] rxSr_q, rxSr_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [DATA_W-1:0] txBuf_q, txBuf_d;
  logic              txFull_q, txFull_d;
  logic [DATA_W-1:0] rxData_q, rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              txUnderrun_q, txUnderrun_d;

  logic sclkEdge, leadingEdge, trailingEdge, sampleEdge, shiftEdge;
  logic loadTx;

  spi_sync_edge #(.RESET_VAL(1'b0)) sclkSync (
    .clk_in (clk_in),
    .rst    (rst),
    .din_i  (bus.sclk),
    .level  (sclkLevel),
    .rise   (sclkRise),
    .fall   (sclkFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) ssSync (
    .clk_in (clk_in),
    .rst    (rst),
    .din_i  (bus.ss_n),
    .level  (ssLevel),
    .rise   (ssRise),
    .fall   (ssFall)
  );

  // MOSI only needs two flops so it lines up with the detected sclk edges.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mosiSync_q <= 2'b00;
    end else begin
      mosiSync_q <= {mosiSync_q[0], bus.mosi};
    end
  end

  assign mosiS = mosiSync_q[1];

  // Leading edge moves sclk away from its idle level; the phase bit picks
  // which of the two edges samples MOSI and which advances MISO.
  assign sclkEdge     = sclkRise | sclkFall;
  assign leadingEdge  = sclkEdge & (sclkLevel != cpol_q);
  assign trailingEdge = sclkEdge & (sclkLevel == cpol_q);
  assign sampleEdge   = (cpha_q == CPHA_LEAD_SAMPLE) ? leadingEdge : trailingEdge;
  assign shiftEdge    = (cpha_q == CPHA_LEAD_SAMPLE) ? trailingEdge : leadingEdge;

  // Next-state logic for the select FSM, both shift registers and the buffer.
  always_comb begin
    state_d      = state_q;
    cpol_d       = cpol_q;
    cpha_d       = cpha_q;
    lsb_d        = lsb_q;
    txSr_d       = txSr_q;
    rxSr_d       = rxSr_q;
    bitCnt_d     = bitCnt_q;
    txBuf_d      = txBuf_q;
    txFull_d     = txFull_q;
    rxData_d     = rxData_q;
    rxValid_d    = 1'b0;
    txUnderrun_d = 1'b0;
    loadTx       = 1'b0;

    case (state_q)
      IDLE: begin
        if (ssFall) begin
          state_d  = ACTIVE;
          cpol_d   = bus.cpol;
          cpha_d   = bus.cpha;
          lsb_d    = bus.lsb;
          bitCnt_d = '0;
          loadTx   = 1'b1;
        end
      end
      ACTIVE: begin
        if (ssRise) begin
          state_d  = IDLE;
          bitCnt_d = '0;
          rxSr_d   = '0;
        end else if (!ssLevel) begin
          if (sampleEdge) begin
            if (lsb_q == ORDER_LSB_FIRST) begin
              rxSr_d = {mosiS, rxSr_q[DATA_W-1:1]};
            end else begin
              rxSr_d = {rxSr_q[DATA_W-2:0], mosiS};
            end
            if (bitCnt_q == LAST_BIT) begin
              rxData_d  = rxSr_d;
              rxValid_d = 1'b1;
              bitCnt_d  = '0;
              loadTx    = 1'b1;
            end else begin
              bitCnt_d = bitCnt_q + CNT_W'(1);
            end
          end else if (shiftEdge && (bitCnt_q != '0)) begin
            if (lsb_q == ORDER_LSB_FIRST) begin
              txSr_d = {1'b1, txSr_q[DATA_W-1:1]};
            end else begin
              txSr_d = {txSr_q[DATA_W-2:0], 1'b1};
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (loadTx) begin
      if (txFull_q) begin
        txSr_d   = txBuf_q;
        txFull_d = 1'b0;
      end else begin
        txSr_d       = '1;
        txUnderrun_d = 1'b1;
      end
    end

    if (bus.tx_load && !txFull_q) begin
      txBuf_d  = bus.tx_data;
      txFull_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cpol_q       <= 1'b0;
      cpha_q       <= 1'b0;
      lsb_q        <= 1'b0;
      txSr_q       <= '0;
      rxSr_q       <= '0;
      bitCnt_q     <= '0;
      txBuf_q      <= '0;
      txFull_q     <= 1'b0;
      rxData_q     <= '0;
      rxValid_q    <= 1'b0;
      txUnderrun_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cpol_q       <= cpol_d;
      cpha_q       <= cpha_d;
      lsb_q        <= lsb_d;
      txSr_q       <= txSr_d;
      rxSr_q       <= rxSr_d;
      bitCnt_q     <= bitCnt_d;
      txBuf_q      <= txBuf_d;
      txFull_q     <= txFull_d;
      rxData_q     <= rxData_d;
      rxValid_q    <= rxValid_d;
      txUnderrun_q <= txUnderrun_d;
    end
  end

  assign bus.miso        = (lsb_q == ORDER_LSB_FIRST) ? txSr_q[0] : txSr_q[DATA_W-1];
  assign bus.miso_oe     = (state_q == ACTIVE);
  assign bus.busy        = (state_q == ACTIVE);
  assign bus.tx_ready    = ~txFull_q;
  assign bus.rx_data     = rxData_q;
  assign bus.rx_valid    = rxValid_q;
  assign bus.tx_underrun = txUnderrun_q;

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Directed bench for spi_slave_shifter: a behavioural SPI master drives the
// pins, and every result is compared against hand-computed values.
module tb_spi_slave_shifter;
  import spi_pkg::*;

  localparam int HALF = 6;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int checks    = 0;
  int failures  = 0;
  int rxValidCnt = 0;
  int underrunCnt = 0;

  logic modeCpol, modeCpha, modeLsb;
  logic [7:0] got, got2;
  int v0, u0;

  spi_slave_shifter_if #(.DATA_W(8)) bus ();

  spi_slave_shifter #(.DATA_W(8)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  // Count single-cycle pulses, sampled mid-cycle.
  always @(negedge clk_in) begin
    if (bus.rx_valid === 1'b1) rxValidCnt <= rxValidCnt + 1;
    if (bus.tx_underrun === 1'b1) underrunCnt <= underrunCnt + 1;
  end

  // Hard stop in case a wait never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic setMode(input logic pol, input logic pha, input logic order);
    modeCpol = pol;
    modeCpha = pha;
    modeLsb  = order;
    bus.cpol = pol;
    bus.cpha = pha;
    bus.lsb  = order;
    bus.sclk = pol;
    waitCycles(8);
  endtask

  task automatic loadTx(input logic [7:0] w);
    @(negedge clk_in);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge clk_in);
    bus.tx_load = 1'b0;
  endtask

  task automatic selectSlave();
    bus.ss_n = 1'b0;
    waitCycles(HALF);
  endtask

  task automatic deselectSlave();
    waitCycles(HALF);
    bus.ss_n = 1'b1;
    waitCycles(8);
  endtask

  // Behavioural SPI master: shifts nBits of outW, captures MISO into inW.
  task automatic applyStimulus(input logic [7:0] outW, input int nBits,
                               output logic [7:0] inW);
    int idx;
    inW = 8'h00;
    for (int i = 0; i < nBits; i++) begin
      idx = modeLsb ? i : 7 - i;
      if (!modeCpha) begin
        bus.mosi = outW[idx];
        waitCycles(HALF);
        bus.sclk = ~modeCpol;
        inW[idx] = bus.miso;
        waitCycles(HALF);
        bus.sclk = modeCpol;
      end else begin
        bus.sclk = ~modeCpol;
        bus.mosi = outW[idx];
        waitCycles(HALF);
        bus.sclk = modeCpol;
        inW[idx] = bus.miso;
        waitCycles(HALF);
      end
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, "_miso"},     32'(bus.miso),        32'd0);
    checkOutput({pfx, "_miso_oe"},  32'(bus.miso_oe),     32'd0);
    checkOutput({pfx, "_rx_data"},  32'(bus.rx_data),     32'd0);
    checkOutput({pfx, "_rx_valid"}, 32'(bus.rx_valid),    32'd0);
    checkOutput({pfx, "_underrun"}, 32'(bus.tx_underrun), 32'd0);
    checkOutput({pfx, "_tx_ready"}, 32'(bus.tx_ready),    32'd1);
    checkOutput({pfx, "_busy"},     32'(bus.busy),        32'd0);
  endtask

  initial begin
    bus.ss_n    = 1'b1;
    bus.sclk    = 1'b0;
    bus.mosi    = 1'b0;
    bus.tx_data = 8'h00;
    bus.tx_load = 1'b0;
    bus.cpol    = CPOL_IDLE_LOW;
    bus.cpha    = 1'b0;
    bus.lsb     = 1'b0;
    modeCpol    = CPOL_IDLE_LOW;
    modeCpha    = 1'b0;
    modeLsb     = 1'b0;

    // Reset state.
    waitCycles(3);
    checkResetValues("reset");
    rst = 1'b0;
    waitCycles(3);

    // Mode 0, MSB first: master sends 0x3C, slave returns 0xA5.
    setMode(1'b0, 1'b0, 1'b0);
    loadTx(8'hA5);
    checkOutput("m0_tx_ready_full", 32'(bus.tx_ready), 32'd0);
    selectSlave();
    checkOutput("m0_busy", 32'(bus.busy), 32'd1);
    checkOutput("m0_miso_oe", 32'(bus.miso_oe), 32'd1);
    checkOutput("m0_tx_ready_empty", 32'(bus.tx_ready), 32'd1);
    v0 = rxValidCnt;
    applyStimulus(8'h3C, 8, got);
    deselectSlave();
    checkOutput("m0_rx_data", 32'(bus.rx_data), 32'h3C);
    checkOutput("m0_rx_valid_cnt", 32'(rxValidCnt - v0), 32'd1);
    checkOutput("m0_master_got", 32'(got), 32'hA5);
    checkOutput("m0_idle_busy", 32'(bus.busy), 32'd0);

    // All four modes in both bit orders.
    for (int m = 0; m < 4; m++) begin
      for (int l = 0; l < 2; l++) begin
        setMode(m[1], m[0], l[0]);
        loadTx(8'h7E);
        selectSlave();
        v0 = rxValidCnt;
        applyStimulus(8'h81, 8, got);
        deselectSlave();
        checkOutput($sformatf("mode%0d_lsb%0d_rx", m, l), 32'(bus.rx_data), 32'h81);
        checkOutput($sformatf("mode%0d_lsb%0d_vcnt", m, l), 32'(rxValidCnt - v0), 32'd1);
        checkOutput($sformatf("mode%0d_lsb%0d_got", m, l), 32'(got), 32'h7E);
      end
    end

    // Asymmetric words in LSB-first order.
    setMode(1'b1, 1'b1, 1'b1);
    loadTx(8'hC2);
    selectSlave();
    applyStimulus(8'h35, 8, got);
    deselectSlave();
    checkOutput("lsb_m3_rx", 32'(bus.rx_data), 32'h35);
    checkOutput("lsb_m3_got", 32'(got), 32'hC2);
    setMode(1'b0, 1'b0, 1'b1);
    loadTx(8'h1D);
    selectSlave();
    applyStimulus(8'h6A, 8, got);
    deselectSlave();
    checkOutput("lsb_m0_rx", 32'(bus.rx_data), 32'h6A);
    checkOutput("lsb_m0_got", 32'(got), 32'h1D);

    // Two back-to-back words inside one select.
    setMode(1'b0, 1'b0, 1'b0);
    loadTx(8'h11);
    selectSlave();
    for (int k = 0; k < 20 && bus.tx_ready !== 1'b1; k++) @(negedge clk_in);
    checkOutput("b2b_tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    loadTx(8'h22);
    checkOutput("b2b_refill_full", 32'(bus.tx_ready), 32'd0);
    v0 = rxValidCnt;
    u0 = underrunCnt;
    applyStimulus(8'hF0, 8, got);
    checkOutput("b2b_rx_first", 32'(bus.rx_data), 32'hF0);
    applyStimulus(8'h0F, 8, got2);
    deselectSlave();
    checkOutput("b2b_got_first", 32'(got), 32'h11);
    checkOutput("b2b_got_second", 32'(got2), 32'h22);
    checkOutput("b2b_rx_second", 32'(bus.rx_data), 32'h0F);
    checkOutput("b2b_vcnt", 32'(rxValidCnt - v0), 32'd2);
    checkOutput("b2b_underrun_end", 32'(underrunCnt - u0), 32'd1);

    // Select with an empty buffer.
    checkOutput("ur_tx_ready", 32'(bus.tx_ready), 32'd1);
    u0 = underrunCnt;
    selectSlave();
    checkOutput("ur_pulse", 32'(underrunCnt - u0), 32'd1);
    applyStimulus(8'h5A, 8, got);
    deselectSlave();
    checkOutput("ur_master_got", 32'(got), 32'hFF);
    checkOutput("ur_rx", 32'(bus.rx_data), 32'h5A);

    // Deselect after five bits, then a clean transfer.
    loadTx(8'h99);
    selectSlave();
    v0 = rxValidCnt;
    applyStimulus(8'hC7, 5, got);
    deselectSlave();
    checkOutput("abort_vcnt", 32'(rxValidCnt - v0), 32'd0);
    checkOutput("abort_rx_held", 32'(bus.rx_data), 32'h5A);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    loadTx(8'h3A);
    selectSlave();
    v0 = rxValidCnt;
    applyStimulus(8'h55, 8, got);
    deselectSlave();
    checkOutput("after_abort_rx", 32'(bus.rx_data), 32'h55);
    checkOutput("after_abort_got", 32'(got), 32'h3A);
    checkOutput("after_abort_vcnt", 32'(rxValidCnt - v0), 32'd1);

    // Reset asserted mid-word.
    loadTx(8'hC3);
    selectSlave();
    loadTx(8'h44);
    applyStimulus(8'h12, 4, got);
    checkOutput("midrst_pre_busy", 32'(bus.busy), 32'd1);
    checkOutput("midrst_pre_tx_ready", 32'(bus.tx_ready), 32'd0);
    @(negedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    checkResetValues("midrst");
    bus.ss_n = 1'b1;
    bus.sclk = 1'b0;
    waitCycles(5);
    rst = 1'b0;
    waitCycles(5);
    checkOutput("post_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_tx_ready", 32'(bus.tx_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
